// File: rtl/cont_decr_param.sv
// cont_decr_param: parametrised down-counter/timer for the irrigation
// controller. Supports a runtime load value, count enable, one-shot or
// auto-reload operation and a registered terminal-count pulse. An
// IDLE/RUN/DONE state machine lets the sequencer start, pause, abort and
// detect the end of a timed interval.
module cont_decr_param #(
    parameter int WIDTH = 3,
    parameter int MAX   = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Clr,
    input  logic             PosMax,
    input  logic             Start,
    input  logic [WIDTH-1:0] Val,
    input  logic             En,
    input  logic             Auto,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Tc,
    output logic             Running,
    output logic             Fin
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] loadVal;

    // A zero load value selects the MAX preset instead.
    assign loadVal = (Val == '0) ? MaxVal : Val;

    // Register update; reset is sampled on the clock edge only.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            rld_q   <= MaxVal;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state logic: Clr > PosMax > Start > counting; Tc is a one-cycle pulse.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (Clr) begin
            q_d     = '0;
            state_d = IDLE;
        end else if (PosMax) begin
            q_d     = MaxVal;
            rld_d   = MaxVal;
            state_d = RUN;
        end else if (Start) begin
            q_d     = loadVal;
            rld_d   = loadVal;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    q_d = q_q;
                end
                RUN: begin
                    if (En) begin
                        if (q_q > OneVal) begin
                            q_d = q_q - OneVal;
                        end else if (q_q == OneVal) begin
                            q_d  = '0;
                            tc_d = 1'b1;
                            if (!Auto) begin
                                state_d = DONE;
                            end
                        end else if (Auto) begin
                            q_d = rld_q;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    q_d = q_q;
                end
                default: begin
                    q_d     = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign Q       = q_q;
    assign Zero    = (q_q == '0);
    assign Tc      = tc_q;
    assign Running = (state_q == RUN);
    assign Fin     = (state_q == DONE);

endmodule

// File: tb/tb_cont_decr_param.sv
// Self-checking bench for cont_decr_param: a table of directed vectors,
// hand-written multi-cycle sequences and a randomized run compared against
// a behavioural model of the timer.
module tb_cont_decr_param;

    localparam int WIDTH = 3;
    localparam int MAX   = 5;

    logic             Clk = 1'b0;
    logic             Rst_n, Clr, PosMax, Start, En, Auto;
    logic [WIDTH-1:0] Val;
    logic [WIDTH-1:0] Q;
    logic             Zero, Tc, Running, Fin;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: a plain integer count plus run/finished flags.
    int mCount  = 0;
    int mReload = MAX;
    bit mRun    = 0;
    bit mDone   = 0;
    bit mTc     = 0;

    typedef struct {
        bit rstN;
        bit clr;
        bit posMax;
        bit start;
        int val;
        bit en;
        bit autoR;
        int expQ;
        bit expTc;
        bit expRun;
        bit expFin;
    } vec_t;

    vec_t vecs[$];

    cont_decr_param #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Clr     (Clr),
        .PosMax  (PosMax),
        .Start   (Start),
        .Val     (Val),
        .En      (En),
        .Auto    (Auto),
        .Q       (Q),
        .Zero    (Zero),
        .Tc      (Tc),
        .Running (Running),
        .Fin     (Fin)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    function automatic vec_t mk(bit rstN, bit clr, bit posMax, bit start, int val,
                                bit en, bit autoR, int expQ, bit expTc, bit expRun, bit expFin);
        vec_t v;
        v.rstN = rstN; v.clr = clr; v.posMax = posMax; v.start = start; v.val = val;
        v.en = en; v.autoR = autoR; v.expQ = expQ; v.expTc = expTc;
        v.expRun = expRun; v.expFin = expFin;
        return v;
    endfunction

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic modelStep(bit rstN, bit clr, bit posMax, bit start, int val, bit en, bit autoR);
        mTc = 0;
        if (!rstN) begin
            mCount = 0; mReload = MAX; mRun = 0; mDone = 0;
        end else if (clr) begin
            mCount = 0; mRun = 0; mDone = 0;
        end else if (posMax) begin
            mCount = MAX; mReload = MAX; mRun = 1; mDone = 0;
        end else if (start) begin
            mReload = (val == 0) ? MAX : val;
            mCount = mReload; mRun = 1; mDone = 0;
        end else if (mRun && en) begin
            if (mCount > 0) begin
                mCount = mCount - 1;
                if (mCount == 0) begin
                    mTc = 1;
                    if (!autoR) begin
                        mRun = 0; mDone = 1;
                    end
                end
            end else if (autoR) begin
                mCount = mReload;
            end else begin
                mRun = 0; mDone = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, keep the model in step, wait past the edge.
    task automatic applyStimulus(bit rstN, bit clr, bit posMax, bit start, int val, bit en, bit autoR);
        Rst_n = rstN; Clr = clr; PosMax = posMax; Start = start;
        Val = WIDTH'(val); En = en; Auto = autoR;
        modelStep(rstN, clr, posMax, start, val, en, autoR);
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkAll(string tag, int expQ, bit expTc, bit expRun, bit expFin);
        checkOutput({tag, ".Q"}, int'(Q), expQ);
        checkOutput({tag, ".Zero"}, int'(Zero), (expQ == 0) ? 1 : 0);
        checkOutput({tag, ".Tc"}, int'(Tc), int'(expTc));
        checkOutput({tag, ".Running"}, int'(Running), int'(expRun));
        checkOutput({tag, ".Fin"}, int'(Fin), int'(expFin));
    endtask

    initial begin
        int tcCount;
        int finSeen;
        int seq3 [14] = '{5, 4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4};

        Rst_n = 0; Clr = 0; PosMax = 0; Start = 0; Val = '0; En = 0; Auto = 0;
        #2;

        // Reset, one-shot count from 3, Start with Val=0, Clr beats Start.
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0,1,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,1,3,1,0, 3,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 2,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 0,1,0,1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,0,1,0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0,0,0, 5,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 4,0,1,0));
        vecs.push_back(mk(1,1,0,1,2,1,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].clr, vecs[i].posMax, vecs[i].start,
                          vecs[i].val, vecs[i].en, vecs[i].autoR);
            checkAll($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expTc,
                     vecs[i].expRun, vecs[i].expFin);
        end

        // Auto-reload from MAX over 14 cycles: two Tc pulses, never finished.
        tcCount = 0;
        finSeen = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 0, (i == 0), 0, 0, 1, 1);
            checkOutput($sformatf("auto.Q%0d", i), int'(Q), seq3[i]);
            tcCount += int'(Tc);
            finSeen += int'(Fin);
        end
        checkOutput("auto.tcCount", tcCount, 2);
        checkOutput("auto.finSeen", finSeen, 0);

        // Auto dropped while sitting at 0 finishes the run.
        applyStimulus(1, 0, 0, 0, 0, 1, 1); checkAll("autoDrop.a", 3, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1); checkAll("autoDrop.b", 2, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1); checkAll("autoDrop.c", 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1); checkAll("autoDrop.d", 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("autoDrop.e", 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1); checkAll("autoDrop.f", 0, 0, 0, 1);

        // Pause at Q=2 for three cycles, then resume to terminal count.
        applyStimulus(1, 0, 0, 1, 4, 1, 0); checkAll("pause.load", 4, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("pause.3", 3, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("pause.2", 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            checkAll($sformatf("pause.hold%0d", i), 2, 0, 1, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("pause.1", 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("pause.0", 0, 1, 0, 1);

        // Reset at Q=1 suppresses the Tc; mid-run restart at Q=3 with Val=6.
        applyStimulus(1, 0, 0, 1, 2, 1, 0); checkAll("rst.load", 2, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("rst.1", 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0); checkAll("rst.hit", 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 5, 1, 0); checkAll("restart.load", 5, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("restart.4", 4, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("restart.3", 3, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 6, 1, 0); checkAll("restart.6", 6, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0); checkAll("restart.5", 5, 0, 1, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit rR, cR, pR, sR, eR, aR;
            int vR;
            rR = ($urandom_range(0, 49) != 0);
            cR = ($urandom_range(0, 29) == 0);
            pR = ($urandom_range(0, 24) == 0);
            sR = ($urandom_range(0, 14) == 0);
            eR = ($urandom_range(0, 3) != 0);
            aR = ($urandom_range(0, 2) != 0);
            vR = int'($urandom_range(0, 7));
            applyStimulus(rR, cR, pR, sR, vR, eR, aR);
            checkAll($sformatf("rand%0d", i), mCount, mTc, mRun, mDone);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cont_decr_param.md
Name: cont_decr_param

Overview:
Parametrised down-counter/timer for the irrigation controller. It generalises the fixed 5→0 counter: configurable width and preset, a runtime load value, count enable, one-shot or auto-reload mode, and a terminal-count pulse. An explicit IDLE/RUN/DONE state machine lets the watering sequencer start, pause, abort and detect the end of a timed interval.

Parameters:
WIDTH, 3, counter width in bits.
MAX, 5, preset value used by PosMax and by Start when Val==0; must satisfy 1 <= MAX <= 2^WIDTH-1.

Ports:
Clk  input  1  rising-edge clock, the only clock.
Rst_n  input  1  synchronous active-low reset.
Clr  input  1  force Q to 0 and go to IDLE.
PosMax  input  1  force Q to MAX and go to RUN.
Start  input  1  load Val and go to RUN.
Val  input  WIDTH  load value for Start; 0 means "use MAX".
En  input  1  count enable; active only in RUN.
Auto  input  1  1 = auto-reload at terminal count, 0 = one-shot.
Q  output  WIDTH  current count, registered.
Zero  output  1  Q==0, decoded from the register.
Tc  output  1  one-cycle terminal-count pulse, registered.
Running  output  1  state==RUN.
Fin  output  1  state==DONE.

Behaviour:
- All updates on the rising edge of Clk. Reset is synchronous: Rst_n sampled low gives Q=0, Rld=MAX, state=IDLE, Tc=0, so Zero=1, Running=0, Fin=0.
- Internal register Rld holds the reload value. It is set to MAX by reset and by PosMax. Start sets it to Val, or to MAX when Val==0.
- Per-cycle priority: Rst_n low > Clr > PosMax > Start > counting. Only the highest active request acts.
- Clr: Q<=0, state<=IDLE, Tc<=0. Rld is unchanged.
- PosMax: Q<=MAX, Rld<=MAX, state<=RUN, Tc<=0.
- Start: Q<=(Val==0 ? MAX : Val), Rld updated the same way, state<=RUN, Tc<=0. Start is accepted in any state, including a restart mid-run.
- Tc defaults to 0 every cycle. It is 1 only in the cycle after a 1→0 decrement, i.e. coincident with Q first reading 0.
- IDLE: Q held; En and Auto ignored.
- RUN, En=0: Q and state held (pause); Tc<=0.
- RUN, En=1:
  - Q>1: Q<=Q-1.
  - Q==1: Q<=0 and Tc<=1. State<=DONE if Auto=0; state stays RUN if Auto=1.
  - Q==0 and Auto=1: Q<=Rld. This gives a wrap of Rld+1 states per period, e.g. 5,4,3,2,1,0,5…
  - Q==0 and Auto=0: state<=DONE, Q stays 0. This covers Auto dropped while at 0.
- DONE: Q held at 0; En ignored; leaves only via Clr (to IDLE), PosMax or Start (to RUN).
- Latency:
  - Load to first decrement is 1 cycle, provided En=1 in the cycle after the load.
  - One-shot from load value N with En held high: Tc rises N cycles after the load edge, and Fin rises in the same cycle.
- Auto sampled 0 on the 1→0 step ends the run even if it is raised later.
- No arithmetic underflow is possible: a decrement never occurs at Q==0.
- Reset mid-run wins over all requests and clears Tc, including a Tc that would have fired this cycle.
- Unused states of the state encoding recover to IDLE with Q=0 on the next edge.

Test Plan:
1. Reset held 2 cycles, then released → Q=0, Zero=1, state IDLE, Tc=0; 4 cycles with En=1 leave Q=0.
2. Start with Val=3, Auto=0, En=1 → Q sequence 3,2,1,0; Tc=1 only in the cycle Q reaches 0; Fin=1, Running=0 and Q stays 0 for 5 more cycles.
3. PosMax, Auto=1, En=1 for 14 cycles → Q: 5,4,3,2,1,0,5,4,3,2,1,0,5,4; Tc pulses exactly twice; Fin never 1.
4. Start with Val=4, En=1; drop En for 3 cycles when Q=2 → Q holds 2 with no Tc; resumes 1,0 and Tc fires when En returns.
5. Start with Val=0, Auto=0 → Q loads 5 (MAX), Rld=5; Clr asserted with Start in the same cycle → Clr wins, Q=0, state IDLE.
6. During RUN at Q=1, drive Rst_n=0 with En=1 → next edge Q=0, Tc=0, Running=0, Fin=0 (no Tc pulse); mid-run Start with Val=6 at Q=3 → Q=6 and the count continues from 6.
